// File: rtl/auc_alu_pkg.sv
// rtl/auc_alu_pkg.sv - shared constants for the GF(2^255-19) modular ALU
package auc_alu_pkg;

   localparam int ALU_WID   = 256;
   localparam int ALU_OPWID = 4;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_MUL  = 4'd4;
   localparam logic [3:0] OP_SQR  = 4'd5;
   localparam logic [3:0] OP_MULC = 4'd6;
   localparam logic [3:0] OP_OUT  = 4'd7;

   localparam logic [ALU_WID-1:0] P     = (256'd1 << 255) - 256'd19;
   localparam logic [ALU_WID-1:0] TWO_P = P << 1;
   localparam logic [ALU_WID-1:0] A24   = 256'd121665;

endpackage

// File: rtl/auc_modmul_serial.sv
// rtl/auc_modmul_serial.sv - bit-serial MSB-first modular multiplier, one bit per cycle
module auc_modmul_serial
   import auc_alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ALU_WID-1:0] x,
   input  logic [ALU_WID-1:0] b,
   output logic               done,
   output logic [ALU_WID-1:0] r
);

   logic               run_q, run_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [ALU_WID-1:0] x_q, x_d;
   logic [ALU_WID-1:0] b_q, b_d;
   logic [ALU_WID-1:0] r_q, r_d;
   logic [ALU_WID-1:0] dbl, dbl_red, sum, sum_red, step;

   // r_q and x_q stay below p, so 2r and r+x both fit in 256 bits
   always_comb begin
      dbl     = r_q << 1;
      dbl_red = (dbl >= P) ? dbl - P : dbl;
      sum     = dbl_red + x_q;
      sum_red = (sum >= P) ? sum - P : sum;
      step    = b_q[cnt_q] ? sum_red : dbl_red;
   end

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      x_d   = x_q;
      b_d   = b_q;
      r_d   = r_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = 8'd255;
         x_d   = x;
         b_d   = b;
         r_d   = '0;
      end else if (run_q) begin
         r_d = step;
         if (cnt_q == 8'd0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         x_q   <= '0;
         b_q   <= '0;
         r_q   <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         x_q   <= x_d;
         b_q   <= b_d;
         r_q   <= r_d;
      end
   end

   // done flags the final iteration; r is that iteration's result, captured by the parent
   assign done = run_q & (cnt_q == 8'd0);
   assign r    = step;

endmodule

// File: rtl/auc_alu_modp.sv
// rtl/auc_alu_modp.sv - accumulator ALU over GF(2^255-19) for the Montgomery-ladder controller
module auc_alu_modp
   import auc_alu_pkg::*;
#(
   parameter int WID   = 256,
   parameter int OPWID = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_en,
   input  logic [OPWID-1:0] alu_opcode,
   input  logic             alu_carry,
   input  logic             alu_swapop,
   input  logic             alu_swapvl,
   input  logic [WID-1:0]   alu_rd,
   output logic             alu_vld,
   output logic [WID-1:0]   alu_dat,
   output logic [WID-1:0]   alu_rswap,
   output logic             alu_busy,
   output logic             alu_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [WID-1:0] a_q, a_d;
   logic [WID-1:0] dat_q, dat_d;
   logic [WID-1:0] rswap_q, rswap_d;
   logic           vld_q, vld_d;
   logic           err_q, err_d;

   logic           busy, accept, mul_start, mul_done;
   logic [WID-1:0] mul_b, mul_r;
   logic [WID:0]   sum_w, diff_w;
   logic [WID-1:0] op_x, op_y, add_res, sub_res, load_res;

   assign busy   = (state_q == ST_MUL);
   assign accept = alu_en & ~busy;

   always_comb begin
      sum_w    = {1'b0, a_q} + {1'b0, alu_rd};
      add_res  = sum_w[WID-1:0] - ((sum_w >= {1'b0, P}) ? P : '0);
      op_x     = alu_carry ? alu_rd : a_q;
      op_y     = alu_carry ? a_q : alu_rd;
      diff_w   = {1'b0, op_x} - {1'b0, op_y};
      sub_res  = diff_w[WID-1:0] + (diff_w[WID] ? P : '0);
      load_res = (alu_rd >= TWO_P) ? alu_rd - TWO_P :
                 (alu_rd >= P)     ? alu_rd - P     : alu_rd;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      dat_d     = dat_q;
      rswap_d   = rswap_q;
      vld_d     = 1'b0;
      err_d     = err_q;
      mul_start = 1'b0;
      mul_b     = alu_rd;
      if (alu_en && busy) begin
         err_d = 1'b1;
      end
      if (state_q == ST_MUL) begin
         if (mul_done) begin
            a_d     = mul_r;
            dat_d   = mul_r;
            vld_d   = 1'b1;
            state_d = ST_DONE;
         end
      end else begin
         // DONE behaves like IDLE so a strobe in the vld cycle is accepted
         state_d = ST_IDLE;
         if (accept) begin
            if (alu_swapop) begin
               vld_d = 1'b1;
               if (alu_swapvl) begin
                  dat_d   = alu_rd;
                  rswap_d = a_q;
                  a_d     = alu_rd;
               end else begin
                  dat_d   = a_q;
                  rswap_d = alu_rd;
               end
            end else begin
               case (alu_opcode)
                  OP_NOP, OP_OUT: begin
                     vld_d = 1'b1;
                     dat_d = a_q;
                  end
                  OP_LOAD: begin
                     vld_d = 1'b1;
                     a_d   = load_res;
                     dat_d = load_res;
                  end
                  OP_ADD: begin
                     vld_d = 1'b1;
                     a_d   = add_res;
                     dat_d = add_res;
                  end
                  OP_SUB: begin
                     vld_d = 1'b1;
                     a_d   = sub_res;
                     dat_d = sub_res;
                  end
                  OP_MUL, OP_SQR, OP_MULC: begin
                     mul_start = 1'b1;
                     state_d   = ST_MUL;
                     if (alu_opcode == OP_SQR) begin
                        mul_b = a_q;
                     end else if (alu_opcode == OP_MULC) begin
                        mul_b = A24;
                     end
                  end
                  default: begin
                     vld_d = 1'b1;
                     dat_d = a_q;
                     err_d = 1'b1;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         dat_q   <= '0;
         rswap_q <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         dat_q   <= dat_d;
         rswap_q <= rswap_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   auc_modmul_serial u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .x     (a_q),
      .b     (mul_b),
      .done  (mul_done),
      .r     (mul_r)
   );

   assign alu_vld   = vld_q;
   assign alu_dat   = dat_q;
   assign alu_rswap = rswap_q;
   assign alu_busy  = busy;
   assign alu_err   = err_q;

endmodule

// File: tb/tb_auc_alu_modp.sv
// tb/tb_auc_alu_modp.sv - directed table, randomized model check and corner sequences for auc_alu_modp
module tb_auc_alu_modp;

   localparam logic [3:0] T_NOP  = 4'd0;
   localparam logic [3:0] T_LOAD = 4'd1;
   localparam logic [3:0] T_ADD  = 4'd2;
   localparam logic [3:0] T_SUB  = 4'd3;
   localparam logic [3:0] T_MUL  = 4'd4;
   localparam logic [3:0] T_SQR  = 4'd5;
   localparam logic [3:0] T_MULC = 4'd6;
   localparam logic [3:0] T_OUT  = 4'd7;
   localparam logic [255:0] PM   = (256'd1 << 255) - 256'd19;

   logic         clk = 1'b0;
   logic         rst;
   logic         alu_en;
   logic [3:0]   alu_opcode;
   logic         alu_carry;
   logic         alu_swapop;
   logic         alu_swapvl;
   logic [255:0] alu_rd;
   logic         alu_vld;
   logic [255:0] alu_dat;
   logic [255:0] alu_rswap;
   logic         alu_busy;
   logic         alu_err;

   always #5 clk = ~clk;

   auc_alu_modp dut (
      .clk        (clk),
      .rst        (rst),
      .alu_en     (alu_en),
      .alu_opcode (alu_opcode),
      .alu_carry  (alu_carry),
      .alu_swapop (alu_swapop),
      .alu_swapvl (alu_swapvl),
      .alu_rd     (alu_rd),
      .alu_vld    (alu_vld),
      .alu_dat    (alu_dat),
      .alu_rswap  (alu_rswap),
      .alu_busy   (alu_busy),
      .alu_err    (alu_err)
   );

   typedef struct {
      logic [3:0]   op;
      logic         carry;
      logic         swapop;
      logic         swapvl;
      logic [255:0] rd;
      logic [255:0] exp_dat;
      logic [255:0] exp_rsw;
      int           exp_lat;
   } vec_t;

   localparam int NV = 23;
   vec_t tv[NV];

   int n_vec = 0;
   int n_bad = 0;
   logic [255:0] m_a, m_rsw;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [255:0] f_mod(input logic [511:0] v);
      logic [511:0] t;
      t = v % {256'b0, PM};
      return t[255:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // reference: A and rswap evolved with plain modular arithmetic
   task automatic model_op(input logic [3:0] op, input logic carry, input logic swapop,
                           input logic swapvl, input logic [255:0] rd,
                           output logic [255:0] edat, output int elat);
      logic [255:0] b;
      elat = 1;
      if (swapop) begin
         if (swapvl) begin
            m_rsw = m_a;
            m_a   = rd;
         end else begin
            m_rsw = rd;
         end
         edat = swapvl ? rd : m_a;
      end else begin
         case (op)
            T_LOAD: m_a = f_mod({256'b0, rd});
            T_ADD:  m_a = f_mod({256'b0, m_a} + {256'b0, rd});
            T_SUB:  m_a = carry ? f_mod({256'b0, rd} + {256'b0, PM} - {256'b0, m_a})
                                : f_mod({256'b0, m_a} + {256'b0, PM} - {256'b0, rd});
            T_MUL, T_SQR, T_MULC: begin
               b    = (op == T_MUL) ? rd : (op == T_SQR) ? m_a : 256'd121665;
               m_a  = f_mod({256'b0, m_a} * {256'b0, b});
               elat = 257;
            end
            default: ;
         endcase
         edat = m_a;
      end
   endtask

   task automatic do_op(input logic [3:0] op, input logic carry, input logic swapop,
                        input logic swapvl, input logic [255:0] rd,
                        output logic [255:0] dat, output logic [255:0] rsw,
                        output int lat, output int bcnt);
      alu_en     = 1'b1;
      alu_opcode = op;
      alu_carry  = carry;
      alu_swapop = swapop;
      alu_swapvl = swapvl;
      alu_rd     = rd;
      @(posedge clk); #1;
      alu_en = 1'b0;
      lat    = 1;
      bcnt   = 0;
      while (!alu_vld && lat < 400) begin
         if (alu_busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      dat = alu_dat;
      rsw = alu_rswap;
      chk("busy_low_at_vld", {255'b0, alu_busy}, 256'd0);
   endtask

   logic [255:0] dat, rsw, edat, rd, ra, rb, two_p, ones;
   logic [3:0]   op;
   logic         c, so, sv;
   int           lat, bcnt, elat, cyc, nv;

   initial begin
      rst = 1'b1; alu_en = 1'b0; alu_opcode = '0; alu_carry = 1'b0;
      alu_swapop = 1'b0; alu_swapvl = 1'b0; alu_rd = '0;
      two_p = PM + PM;
      ones  = '1;

      tv[0]  = '{T_LOAD, 0, 0, 0, 256'd5,       256'd5,      256'd0, 1};
      tv[1]  = '{T_ADD,  0, 0, 0, 256'd7,       256'd12,     256'd0, 1};
      tv[2]  = '{T_LOAD, 0, 0, 0, 256'd3,       256'd3,      256'd0, 1};
      tv[3]  = '{T_SUB,  0, 0, 0, 256'd5,       PM - 2,      256'd0, 1};
      tv[4]  = '{T_SUB,  1, 0, 0, 256'd1,       256'd3,      256'd0, 1};
      tv[5]  = '{T_LOAD, 0, 0, 0, ones,         256'd37,     256'd0, 1};
      tv[6]  = '{T_LOAD, 0, 0, 0, PM,           256'd0,      256'd0, 1};
      tv[7]  = '{T_LOAD, 0, 0, 0, two_p + 5,    256'd5,      256'd0, 1};
      tv[8]  = '{T_LOAD, 0, 0, 0, 256'd1,       256'd1,      256'd0, 1};
      tv[9]  = '{T_ADD,  0, 0, 0, PM - 1,       256'd0,      256'd0, 1};
      tv[10] = '{T_LOAD, 0, 0, 0, PM - 1,       PM - 1,      256'd0, 1};
      tv[11] = '{T_SQR,  0, 0, 0, 256'd0,       256'd1,      256'd0, 257};
      tv[12] = '{T_LOAD, 0, 0, 0, 256'd2,       256'd2,      256'd0, 1};
      tv[13] = '{T_MULC, 0, 0, 0, 256'd0,       256'd243330, 256'd0, 257};
      tv[14] = '{T_LOAD, 0, 0, 0, 256'd2,       256'd2,      256'd0, 1};
      tv[15] = '{T_MUL,  0, 0, 0, 256'd3,       256'd6,      256'd0, 257};
      tv[16] = '{T_LOAD, 0, 0, 0, 256'd9,       256'd9,      256'd0, 1};
      tv[17] = '{T_NOP,  0, 1, 1, 256'd4,       256'd4,      256'd9, 1};
      tv[18] = '{T_ADD,  0, 1, 0, 256'd7,       256'd4,      256'd7, 1};
      tv[19] = '{T_NOP,  0, 0, 0, 256'd123,     256'd4,      256'd7, 1};
      tv[20] = '{T_OUT,  0, 0, 0, 256'd55,      256'd4,      256'd7, 1};
      tv[21] = '{T_ADD,  0, 0, 0, PM - 1,       256'd3,      256'd7, 1};
      tv[22] = '{T_SUB,  0, 0, 0, 256'd3,       256'd0,      256'd7, 1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld",   {255'b0, alu_vld},  256'd0);
      chk("rst_dat",   alu_dat,            256'd0);
      chk("rst_rswap", alu_rswap,          256'd0);
      chk("rst_busy",  {255'b0, alu_busy}, 256'd0);
      chk("rst_err",   {255'b0, alu_err},  256'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         do_op(tv[i].op, tv[i].carry, tv[i].swapop, tv[i].swapvl, tv[i].rd, dat, rsw, lat, bcnt);
         chk($sformatf("tv%0d_dat", i), dat, tv[i].exp_dat);
         chk($sformatf("tv%0d_rswap", i), rsw, tv[i].exp_rsw);
         chk_int($sformatf("tv%0d_lat", i), lat, tv[i].exp_lat);
         chk_int($sformatf("tv%0d_busy", i), bcnt, tv[i].exp_lat - 1);
      end
      m_a   = tv[NV-1].exp_dat;
      m_rsw = tv[NV-1].exp_rsw;

      for (int i = 0; i < 40; i++) begin
         c  = 1'($urandom_range(0, 1));
         sv = 1'($urandom_range(0, 1));
         so = 1'b0;
         rd = f_mod({256'b0, rnd256()});
         case ($urandom_range(0, 8))
            0: begin op = T_LOAD; rd = rnd256(); end
            1: op = T_ADD;
            2: op = T_SUB;
            3: op = T_MUL;
            4: op = T_SQR;
            5: op = T_MULC;
            6: begin op = 4'($urandom_range(0, 7)); so = 1'b1; end
            7: op = T_NOP;
            default: op = T_OUT;
         endcase
         model_op(op, c, so, sv, rd, edat, elat);
         do_op(op, c, so, sv, rd, dat, rsw, lat, bcnt);
         chk($sformatf("rnd%0d_dat", i), dat, edat);
         chk($sformatf("rnd%0d_rswap", i), rsw, m_rsw);
         chk_int($sformatf("rnd%0d_lat", i), lat, elat);
      end
      chk("err_clean", {255'b0, alu_err}, 256'd0);

      do_op(4'd9, 1'b0, 1'b0, 1'b0, 256'd11, dat, rsw, lat, bcnt);
      chk("illegal_dat", dat, m_a);
      chk_int("illegal_lat", lat, 1);
      chk("illegal_err", {255'b0, alu_err}, 256'd1);
      do_op(T_OUT, 1'b0, 1'b0, 1'b0, 256'd0, dat, rsw, lat, bcnt);
      chk("illegal_a_kept", dat, m_a);

      rst = 1'b1;
      @(posedge clk); #1;
      chk("err_cleared", {255'b0, alu_err}, 256'd0);
      @(negedge clk); rst = 1'b0;
      m_a = '0; m_rsw = '0;

      // strobe during busy cycle 10 must be ignored but flag err
      ra = f_mod({256'b0, rnd256()});
      rb = f_mod({256'b0, rnd256()});
      do_op(T_LOAD, 1'b0, 1'b0, 1'b0, ra, dat, rsw, lat, bcnt);
      alu_en = 1'b1; alu_opcode = T_MUL; alu_rd = rb;
      @(posedge clk); #1;
      alu_en = 1'b0;
      cyc = 1;
      repeat (9) begin @(posedge clk); #1; cyc++; end
      chk("busy_at_10", {255'b0, alu_busy}, 256'd1);
      alu_en = 1'b1; alu_opcode = T_LOAD; alu_rd = 256'd77;
      @(posedge clk); #1;
      alu_en = 1'b0; cyc++;
      chk("err_on_busy_strobe", {255'b0, alu_err}, 256'd1);
      while (!alu_vld && cyc < 400) begin @(posedge clk); #1; cyc++; end
      chk_int("mul_err_lat", cyc, 257);
      chk("mul_err_dat", alu_dat, f_mod({256'b0, ra} * {256'b0, rb}));
      @(posedge clk); #1;
      chk("no_extra_vld", {255'b0, alu_vld}, 256'd0);

      // reset at busy cycle 100 of a second MUL
      alu_en = 1'b1; alu_opcode = T_MUL; alu_rd = rb;
      @(posedge clk); #1;
      alu_en = 1'b0;
      repeat (99) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_vld",   {255'b0, alu_vld},  256'd0);
      chk("mrst_dat",   alu_dat,            256'd0);
      chk("mrst_rswap", alu_rswap,          256'd0);
      chk("mrst_busy",  {255'b0, alu_busy}, 256'd0);
      chk("mrst_err",   {255'b0, alu_err},  256'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      nv = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (alu_vld || alu_busy) nv++;
      end
      chk_int("no_vld_after_rst", nv, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/auc_alu_modp.md
Name: auc_alu_modp

Overview:
- Modular arithmetic unit over GF(2^255-19). It sits directly downstream of the Montgomery-ladder controller and its init/comp/final sub-FSMs.
- It consumes the controller's opcode, enable, carry and swap strobes, plus the RAM read data the controller addresses.
- It returns a result (alu_vld/alu_dat) for the controller to write back, and a swap partner (alu_rswap).
- It holds one accumulator register A; every operation combines A with the RAM operand.

Parameters:
- WID, 256, datapath width.
- OPWID, 4, opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- alu_en  in  1  one-cycle operation strobe (controller auen)
- alu_opcode  in  OPWID  operation code
- alu_carry  in  1  SUB operand-order select
- alu_swapop  in  1  conditional-swap operation; overrides alu_opcode
- alu_swapvl  in  1  swap bit for conditional swap
- alu_rd  in  WID  RAM operand; valid in the cycle alu_en is high
- alu_vld  out  1  one-cycle result strobe (controller auvld)
- alu_dat  out  WID  result, held until next alu_vld (controller audat)
- alu_rswap  out  WID  swap partner, held until next alu_vld (controller aurswap)
- alu_busy  out  1  multi-cycle operation in progress
- alu_err  out  1  sticky: strobe while busy, or illegal opcode

Behaviour:
- Reset (async, any time, including mid-MUL): A=0, alu_vld=0, alu_dat=0, alu_rswap=0, alu_busy=0, alu_err=0, serial multiplier returns to idle. Reset is the only way to clear alu_err.
- Invariant: A < p at all times; p = 2^255-19. Operands other than LOAD must be < p; results of ADD/SUB/MUL are always < p.
- Single-cycle ops: alu_en at cycle t gives alu_vld=1 at t+1 with alu_dat = new A. alu_rswap is unchanged except for CSWAP.
  - 0 NOP: A unchanged; alu_vld still pulses, alu_dat=A.
  - 1 LOAD: A = alu_rd reduced mod p. Subtract 2p if alu_rd >= 2p, else subtract p if alu_rd >= p.
  - 2 ADD: A = (A+alu_rd) mod p. 257-bit sum, one conditional subtract.
  - 3 SUB: carry=0 gives A = (A-alu_rd) mod p; carry=1 gives A = (alu_rd-A) mod p. Add p when the borrow is set.
  - 7 OUT: A unchanged, alu_dat=A.
- CSWAP (alu_swapop=1, opcode ignored):
  - swapvl=1: alu_dat=alu_rd, alu_rswap=A, A=alu_rd.
  - swapvl=0: alu_dat=A, alu_rswap=alu_rd, A unchanged.
  - Latency 1.
- Multi-cycle ops:
  - 4 MUL: B=alu_rd.
  - 5 SQR: B=A.
  - 6 MULC: B=121665 (a24).
  - Computation: X=A, R=0. For i=255 down to 0: R=2R mod p, then if B[i], R=R+X mod p. Each step is one iteration per cycle with two conditional subtracts.
  - alu_busy=1 from t+1 through t+256; alu_vld=1 at t+257 with A=alu_dat=R; alu_busy low in that same cycle.
- Back-to-back: a new alu_en is accepted in the cycle alu_vld is high, or any later idle cycle.
- alu_en while alu_busy: ignored (no state change), alu_err=1, current operation completes normally.
- Opcodes 8-15 with swapop=0: treated as NOP (alu_vld pulses, A unchanged), alu_err=1.
- No alu_vld is ever produced without a preceding accepted alu_en.
- Main FSM: IDLE -> (en & multi-cycle op) -> MUL -> (bit counter reaches 0) -> DONE (drives vld) -> IDLE. Single-cycle ops stay in IDLE and register vld directly.
- Bit counter: 8 bits, loads 255, decrements to 0, no wrap.

Decomposition:
- Package auc_alu_pkg holds:
  - opcode constants OP_NOP/LOAD/ADD/SUB/MUL/SQR/MULC/OUT
  - P (255'h7FFF...FFED, WID wide)
  - TWO_P
  - A24 = 121665
- Sub-module auc_modmul_serial implements the multi-cycle multiply.
  - Ports: clk, rst, start, x, b → done, r.
  - Contains the bit counter and the double/add-reduce step.
  - The top module contains the decode, the single-cycle ops, A, and the output registers.

Test Plan:
- LOAD 5, then ADD 7 (carry=0) -> alu_vld one cycle after each strobe; alu_dat=5, then 12.
- LOAD 3; SUB 5 carry=0 -> alu_dat = p-2. Then A=p-2; SUB 1 with carry=1 -> alu_dat = (1-(p-2)) mod p = 3.
- LOAD 2^256-1 -> alu_dat=37. LOAD p -> 0. Then ADD p-1 with A=1 -> 0.
- LOAD p-1; SQR -> alu_busy high exactly 256 cycles, alu_vld at cycle 257, alu_dat=1. LOAD 2; MULC -> 243330. LOAD 2; MUL with alu_rd=3 -> 6.
- LOAD 9; CSWAP swapvl=1, alu_rd=4 -> alu_dat=4, alu_rswap=9, A=4. Then CSWAP swapvl=0, alu_rd=7 -> alu_dat=4, alu_rswap=7.
- Start MUL, pulse alu_en at busy cycle 10 -> alu_err=1 and the result is still correct. Start a second MUL and assert rst at busy cycle 100 -> all outputs 0 immediately, no later alu_vld.
